// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory req/rec port between CHANNELS masters.
// A per-transaction watchdog aborts a hung downstream access, answers the master
// with all-ones data and raises a sticky bus_error.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   S_IDLE    | evaluate requests, latch the winner into mem_*
//   S_ACTIVE  | downstream request outstanding, watchdog running
//   S_RELEASE | wait for granted ch_req and mem_rec to both drop
module mem_arbiter #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 256
) (
    input  logic                         mclk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          ch_req,
    input  logic [CHANNELS-1:0]          ch_rw,
    input  logic [CHANNELS*ADDR_W-1:0]   ch_address,
    input  logic [CHANNELS*DATA_W-1:0]   ch_write_data,
    input  logic [CHANNELS*2-1:0]        ch_size,
    output logic [CHANNELS-1:0]          ch_rec,
    output logic [DATA_W-1:0]            ch_read_data,
    output logic                         mem_rw_req,
    output logic                         mem_rw,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_write_data,
    output logic [1:0]                   mem_size,
    input  logic [DATA_W-1:0]            mem_read_data,
    input  logic                         mem_rec,
    output logic                         bus_error,
    output logic [2:0]                   error_chan
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                mem_rw_req_q, mem_rw_req_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic [CHANNELS-1:0] ch_rec_q, ch_rec_d;
    logic [DATA_W-1:0]   ch_read_data_q, ch_read_data_d;
    logic                bus_error_q, bus_error_d;
    logic [2:0]          error_chan_q, error_chan_d;

    logic [3:0]          cand;
    logic [3:0]          nxt_sum;
    logic [2:0]          sel_ch;
    logic [2:0]          rr_next;
    logic                any_req;
    logic [CHANNELS-1:0] sel_onehot;
    logic [CHANNELS-1:0] grant_onehot;
    logic                grant_req;

    // Pick the first requester at or above rr_ptr (modulo CHANNELS); the
    // descending loop lets the smallest rotation distance win.
    always_comb begin
        cand    = '0;
        sel_ch  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + 4'(i);
            if (cand >= 4'(CHANNELS)) begin
                cand = cand - 4'(CHANNELS);
            end
            if (|(ch_req & (CHANNELS'(1) << cand))) begin
                sel_ch = cand[2:0];
            end
        end
        nxt_sum = {1'b0, sel_ch} + 4'd1;
        if (nxt_sum >= 4'(CHANNELS)) begin
            nxt_sum = '0;
        end
        rr_next      = nxt_sum[2:0];
        any_req      = |ch_req;
        sel_onehot   = CHANNELS'(1) << sel_ch;
        grant_onehot = CHANNELS'(1) << grant_q;
        grant_req    = |(ch_req & grant_onehot);
    end

    // Next-state and datapath decisions for the arbitration FSM.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_d          = grant_q;
        wd_cnt_d         = wd_cnt_q;
        mem_rw_req_d     = mem_rw_req_q;
        mem_rw_d         = mem_rw_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_size_d       = mem_size_q;
        ch_rec_d         = '0;
        ch_read_data_d   = ch_read_data_q;
        bus_error_d      = bus_error_q;
        error_chan_d     = error_chan_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d          = sel_ch;
                    rr_ptr_d         = rr_next;
                    mem_rw_d         = |(ch_rw & sel_onehot);
                    mem_address_d    = ch_address[int'(sel_ch) * ADDR_W +: ADDR_W];
                    mem_write_data_d = ch_write_data[int'(sel_ch) * DATA_W +: DATA_W];
                    mem_size_d       = ch_size[int'(sel_ch) * 2 +: 2];
                    mem_rw_req_d     = 1'b1;
                    wd_cnt_d         = WD_W'(TIMEOUT);
                    state_d          = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // A response on the expiry cycle takes priority over the abort.
                if (mem_rec) begin
                    ch_rec_d       = grant_onehot;
                    ch_read_data_d = mem_read_data;
                    mem_rw_req_d   = 1'b0;
                    state_d        = S_RELEASE;
                end else if (TIMEOUT != 0) begin
                    wd_cnt_d = wd_cnt_q - WD_W'(1);
                    if (wd_cnt_q == WD_W'(1)) begin
                        ch_rec_d       = grant_onehot;
                        ch_read_data_d = '1;
                        mem_rw_req_d   = 1'b0;
                        bus_error_d    = 1'b1;
                        error_chan_d   = grant_q;
                        state_d        = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                // Late responses to an aborted access are swallowed here.
                if (!grant_req && !mem_rec) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            rr_ptr_q         <= '0;
            grant_q          <= '0;
            wd_cnt_q         <= '0;
            mem_rw_req_q     <= 1'b0;
            mem_rw_q         <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_size_q       <= '0;
            ch_rec_q         <= '0;
            ch_read_data_q   <= '0;
            bus_error_q      <= 1'b0;
            error_chan_q     <= '0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            grant_q          <= grant_d;
            wd_cnt_q         <= wd_cnt_d;
            mem_rw_req_q     <= mem_rw_req_d;
            mem_rw_q         <= mem_rw_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_size_q       <= mem_size_d;
            ch_rec_q         <= ch_rec_d;
            ch_read_data_q   <= ch_read_data_d;
            bus_error_q      <= bus_error_d;
            error_chan_q     <= error_chan_d;
        end
    end

    assign mem_rw_req     = mem_rw_req_q;
    assign mem_rw         = mem_rw_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_size       = mem_size_q;
    assign ch_rec         = ch_rec_q;
    assign ch_read_data   = ch_read_data_q;
    assign bus_error      = bus_error_q;
    assign error_chan     = error_chan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with 3 channels and a 16-cycle watchdog.
module tb_mem_arbiter;

    localparam int CH = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              mclk = 1'b0;
    logic              reset;
    logic [CH-1:0]     ch_req;
    logic [CH-1:0]     ch_rw;
    logic [CH*AW-1:0]  ch_address;
    logic [CH*DW-1:0]  ch_write_data;
    logic [CH*2-1:0]   ch_size;
    logic [CH-1:0]     ch_rec;
    logic [DW-1:0]     ch_read_data;
    logic              mem_rw_req;
    logic              mem_rw;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_write_data;
    logic [1:0]        mem_size;
    logic [DW-1:0]     mem_read_data;
    logic              mem_rec;
    logic              bus_error;
    logic [2:0]        error_chan;

    mem_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .mclk(mclk), .reset(reset),
        .ch_req(ch_req), .ch_rw(ch_rw), .ch_address(ch_address),
        .ch_write_data(ch_write_data), .ch_size(ch_size),
        .ch_rec(ch_rec), .ch_read_data(ch_read_data),
        .mem_rw_req(mem_rw_req), .mem_rw(mem_rw), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_size(mem_size),
        .mem_read_data(mem_read_data), .mem_rec(mem_rec),
        .bus_error(bus_error), .error_chan(error_chan)
    );

    always #5 mclk = ~mclk;

    int n_pass = 0;
    int n_total = 0;

    logic [AW-1:0] exp_addr [CH] = '{32'h18, 32'h24, 32'h30};
    logic [DW-1:0] exp_wd   [CH] = '{32'hA0A0A0A0, 32'h12345678, 32'hA2A2A2A2};
    logic [1:0]    exp_size [CH] = '{2'd2, 2'd1, 2'd0};
    logic [CH*AW-1:0] base_addr;
    logic [CH*DW-1:0] base_wd;
    logic [CH*2-1:0]  base_size;

    typedef struct {
        logic [CH-1:0] mask;
        logic [CH-1:0] rw;
        int            lat;
        logic [DW-1:0] data;
        int            grant;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic restore_inputs();
        ch_address    = base_addr;
        ch_write_data = base_wd;
        ch_size       = base_size;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_mem_rw_req"}, mem_rw_req, 0);
        chk({tag, "_mem_rw"}, mem_rw, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_write_data"}, mem_write_data, 0);
        chk({tag, "_mem_size"}, mem_size, 0);
        chk({tag, "_ch_rec"}, ch_rec, 0);
        chk({tag, "_ch_read_data"}, ch_read_data, 0);
        chk({tag, "_bus_error"}, bus_error, 0);
        chk({tag, "_error_chan"}, error_chan, 0);
    endtask

    // Waits for mem_rw_req, returning the number of negedges it took.
    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!mem_rw_req && n < 20);
    endtask

    // One complete transaction; called just after a negedge with the DUT idle.
    task automatic run_txn(input vec_t v);
        int n;
        int g;
        logic stable;
        logic [CH-1:0] g_oh;
        g = v.grant;
        g_oh = CH'(1) << g;
        ch_req = v.mask;
        ch_rw  = v.rw;
        wait_req(n);
        chk("req_latency", n, 1);
        chk("grant_addr", mem_address, exp_addr[g]);
        chk("grant_rw", mem_rw, v.rw[g]);
        chk("grant_wdata", mem_write_data, exp_wd[g]);
        chk("grant_size", mem_size, exp_size[g]);
        ch_address    = ~base_addr;
        ch_write_data = ~base_wd;
        ch_size       = ~base_size;
        ch_rw         = ~v.rw;
        stable = 1'b1;
        for (int i = 0; i < v.lat - 1; i++) begin
            @(negedge mclk);
            if (mem_rw_req !== 1'b1 || mem_address !== exp_addr[g] || mem_rw !== v.rw[g] ||
                mem_write_data !== exp_wd[g] || mem_size !== exp_size[g] || ch_rec !== '0)
                stable = 1'b0;
        end
        chk("active_stable", stable, 1);
        mem_rec = 1'b1;
        mem_read_data = v.data;
        @(negedge mclk);
        mem_rec = 1'b0;
        mem_read_data = '0;
        restore_inputs();
        ch_rw  = v.rw;
        ch_req = v.mask & ~g_oh;
        chk("rec_pulse", ch_rec, g_oh);
        if (!v.rw[g]) chk("rec_data", ch_read_data, v.data);
        chk("req_cleared", mem_rw_req, 0);
        @(negedge mclk);
        chk("rec_one_cycle", ch_rec, 0);
    endtask

    initial begin
        int n;
        logic quiet;
        base_addr = {exp_addr[2], exp_addr[1], exp_addr[0]};
        base_wd   = {exp_wd[2], exp_wd[1], exp_wd[0]};
        base_size = {exp_size[2], exp_size[1], exp_size[0]};
        restore_inputs();
        reset = 1'b1;
        ch_req = '0;
        ch_rw = '0;
        mem_rec = 1'b0;
        mem_read_data = '0;

        //            mask    rw      lat data          grant
        vecs.push_back('{3'b001, 3'b000, 3, 32'hDEADBEEF, 0});
        vecs.push_back('{3'b111, 3'b000, 2, 32'h11111111, 1});
        vecs.push_back('{3'b111, 3'b000, 2, 32'h22222222, 2});
        vecs.push_back('{3'b111, 3'b000, 2, 32'h33333333, 0});
        vecs.push_back('{3'b111, 3'b000, 2, 32'h44444444, 1});
        vecs.push_back('{3'b111, 3'b000, 2, 32'h55555555, 2});
        vecs.push_back('{3'b111, 3'b000, 2, 32'h66666666, 0});
        vecs.push_back('{3'b010, 3'b000, 2, 32'h77777777, 1});
        vecs.push_back('{3'b110, 3'b000, 2, 32'h88888888, 2});
        vecs.push_back('{3'b110, 3'b000, 2, 32'h99999999, 1});
        vecs.push_back('{3'b010, 3'b010, 4, 32'hAAAAAAAA, 1});
        vecs.push_back('{3'b101, 3'b000, 1, 32'hBBBBBBBB, 2});

        repeat (2) @(negedge mclk);
        reset_values("reset");
        reset = 1'b0;
        @(negedge mclk);

        foreach (vecs[k]) run_txn(vecs[k]);

        // Watchdog abort on channel 1 (rr_ptr now 0, only ch1 asks).
        ch_req = 3'b010;
        wait_req(n);
        chk("to_req_latency", n, 1);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (ch_rec == '0 && n < 40);
        chk("to_cycles", n, TO);
        chk("to_rec", ch_rec, 3'b010);
        chk("to_data", ch_read_data, 32'hFFFFFFFF);
        chk("to_bus_error", bus_error, 1);
        chk("to_error_chan", error_chan, 1);
        chk("to_req_dropped", mem_rw_req, 0);
        mem_rec = 1'b1;
        mem_read_data = 32'h5A5A5A5A;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge mclk);
            if (ch_rec !== '0 || mem_rw_req !== 1'b0) quiet = 1'b0;
        end
        mem_rec = 1'b0;
        @(negedge mclk);
        if (ch_rec !== '0) quiet = 1'b0;
        chk("late_rec_swallowed", quiet, 1);
        chk("late_rec_data_kept", ch_read_data, 32'hFFFFFFFF);
        ch_req = '0;
        @(negedge mclk);
        chk("bus_error_sticky", bus_error, 1);

        // mem_rec on the expiry cycle completes normally (channel 0).
        ch_req = 3'b001;
        wait_req(n);
        chk("race_req_latency", n, 1);
        repeat (TO - 1) @(negedge mclk);
        chk("race_still_active", mem_rw_req, 1);
        mem_rec = 1'b1;
        mem_read_data = 32'hCAFEF00D;
        @(negedge mclk);
        mem_rec = 1'b0;
        ch_req = '0;
        chk("race_rec", ch_rec, 3'b001);
        chk("race_data", ch_read_data, 32'hCAFEF00D);
        chk("race_error_chan", error_chan, 1);
        @(negedge mclk);

        // Asynchronous reset while channel 1 is active (rr_ptr becomes 2).
        ch_req = 3'b010;
        wait_req(n);
        chk("rst_req_latency", n, 1);
        chk("rst_grant_addr", mem_address, exp_addr[1]);
        @(negedge mclk);
        reset = 1'b1;
        ch_req = '0;
        #1;
        reset_values("async_reset");
        @(negedge mclk);
        reset = 1'b0;
        @(negedge mclk);
        run_txn('{3'b111, 3'b000, 2, 32'h0BADCAFE, 0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
